sram_1rw_wmask_ctrl: RTL

SRAM_1RW_WMASK_CTRL -- requirements
Module: sram_1rw_wmask_ctrl

---
 rtl/sram_1rw_wmask_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sram_1rw_wmask_ctrl.sv
// Single-port SRAM controller: zero-fill sweep after reset, masked writes,
// reads returned in order through a 3-entry response FIFO.
module sram_1rw_wmask_ctrl #(
   parameter int DATA_WIDTH    = 2,
   parameter int ADDR_WIDTH    = 4,
   parameter int NUM_WMASKS    = 2,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                  clk0,
   input  logic                  rstb0,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_web,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_din,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_dout,
   output logic                  init_done,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  sweep_end_q, sweep_end_d;

   logic                  csb_d, web_d;
   logic [NUM_WMASKS-1:0] wmask_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] din_d;

   logic                  p1_q, p2_q;
   logic [1:0]            fcnt_q, wr_q, rd_q;
   logic [DATA_WIDTH-1:0] fifo_q [0:2];

   logic [2:0]            occ;
   logic                  accept, rd_acc, wr_acc;
   logic                  push, pop;

   // occupancy counts every read not yet handed to the consumer
   assign occ       = {2'b0, p1_q} + {2'b0, p2_q} + {1'b0, fcnt_q};
   assign req_ready = (state_q == RUN) && (occ < 3'd3);
   assign init_done = (state_q == RUN);

   assign accept = req_valid && req_ready;
   assign rd_acc = accept && req_web;
   assign wr_acc = accept && !req_web && (|req_wmask);

   assign rsp_valid = (fcnt_q != 2'd0);
   assign rsp_dout  = fifo_q[rd_q];
   assign push      = p2_q;
   assign pop       = rsp_valid && rsp_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sweep_end_d = sweep_end_q;
      csb_d       = 1'b1;
      web_d       = 1'b1;
      wmask_d     = wmask0;
      addr_d      = addr0;
      din_d       = din0;
      unique case (state_q)
         INIT: begin
            if (INIT_ON_RESET == 0 || sweep_end_q) begin
               state_d     = RUN;
               sweep_end_d = 1'b0;
            end else begin
               csb_d       = 1'b0;
               web_d       = 1'b0;
               wmask_d     = '1;
               din_d       = '0;
               addr_d      = cnt_q;
               cnt_d       = cnt_q + 1'b1;
               sweep_end_d = (cnt_q == '1);
            end
         end
         RUN: begin
            unique case (1'b1)
               wr_acc: begin
                  csb_d   = 1'b0;
                  web_d   = 1'b0;
                  addr_d  = req_addr;
                  din_d   = req_din;
                  wmask_d = req_wmask;
               end
               rd_acc: begin
                  csb_d   = 1'b0;
                  addr_d  = req_addr;
                  wmask_d = '0;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         sweep_end_q <= 1'b0;
         csb0        <= 1'b1;
         web0        <= 1'b1;
         wmask0      <= '0;
         addr0       <= '0;
         din0        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sweep_end_q <= sweep_end_d;
         csb0        <= csb_d;
         web0        <= web_d;
         wmask0      <= wmask_d;
         addr0       <= addr_d;
         din0        <= din_d;
      end
   end

   // dout0 is valid one edge after the SRAM captures the read
   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         p1_q   <= 1'b0;
         p2_q   <= 1'b0;
         fcnt_q <= 2'd0;
         wr_q   <= 2'd0;
         rd_q   <= 2'd0;
         for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
      end else begin
         p1_q <= rd_acc;
         p2_q <= p1_q;
         if (push) begin
            fifo_q[wr_q] <= dout0;
            wr_q <= (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
         end
         if (pop) rd_q <= (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
         if (push && !pop)      fcnt_q <= fcnt_q + 2'd1;
         else if (!push && pop) fcnt_q <= fcnt_q - 2'd1;
      end
   end

endmodule
